// File: rtl/y86_decode_stage.sv
// y86_decode_stage: Y86 decode stage with the 8-entry register file and the D->E
// pipeline register.
//
// Build option: define LOADUSE_DETECT_EN to enable internal load-use hazard
// detection. When it is undefined, load_use_stall is tied to 0 and hazards must be
// handled upstream through e_bubble.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   d_*                   decode-slot instruction fields (valid, icode, ifun, rA, rB,
//                         valC, valP)
//   e_stall, e_bubble     E register hold / NOP-load controls (bubble wins)
//   wb_dstE/valE,
//   wb_dstM/valM          writeback ports (M wins on same-register collision)
//   E_*                   registered decode results for the execute stage
//   load_use_stall        combinational request to stall F/D
module y86_decode_stage #(
    parameter int unsigned DATA_W = 32,
    parameter logic [3:0]  RNONE  = 4'hF,
    parameter logic [3:0]  RESP   = 4'h4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_valid,
    input  logic [3:0]        d_icode,
    input  logic [3:0]        d_ifun,
    input  logic [3:0]        d_rA,
    input  logic [3:0]        d_rB,
    input  logic [DATA_W-1:0] d_valC,
    input  logic [DATA_W-1:0] d_valP,
    input  logic              e_stall,
    input  logic              e_bubble,
    input  logic [3:0]        wb_dstE,
    input  logic [DATA_W-1:0] wb_valE,
    input  logic [3:0]        wb_dstM,
    input  logic [DATA_W-1:0] wb_valM,
    output logic              E_valid,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [3:0]        E_srcA,
    output logic [3:0]        E_srcB,
    output logic [3:0]        E_dstE,
    output logic [3:0]        E_dstM,
    output logic              load_use_stall
);

    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVL = 4'h2;
    localparam logic [3:0] IIRMOVL = 4'h3;
    localparam logic [3:0] IRMMOVL = 4'h4;
    localparam logic [3:0] IMRMOVL = 4'h5;
    localparam logic [3:0] IOPL    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHL  = 4'hA;
    localparam logic [3:0] IPOPL   = 4'hB;

    logic [DATA_W-1:0] regFile [8];

    logic [3:0]        srcA, srcB, dstE, dstM;
    logic [DATA_W-1:0] rdA, rdB, valA;
    logic              bubble;

    // Register-ID decode; halt, nop, jXX and undefined icodes use no registers.
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (d_icode)
            IRRMOVL: begin srcA = d_rA; dstE = d_rB; end
            IIRMOVL: dstE = d_rB;
            IRMMOVL: begin srcA = d_rA; srcB = d_rB; end
            IMRMOVL: begin srcB = d_rB; dstM = d_rA; end
            IOPL:    begin srcA = d_rA; srcB = d_rB; dstE = d_rB; end
            ICALL:   begin srcB = RESP; dstE = RESP; end
            IRET:    begin srcA = RESP; srcB = RESP; dstE = RESP; end
            IPUSHL:  begin srcA = d_rA; srcB = RESP; dstE = RESP; end
            IPOPL:   begin srcA = RESP; srcB = RESP; dstE = RESP; dstM = d_rA; end
            default: ;
        endcase
    end

    // Read port with write-through; valM is checked first so it wins a collision.
    function automatic logic [DATA_W-1:0] readReg(
        input logic [3:0]        id,
        input logic [DATA_W-1:0] stored,
        input logic [3:0]        wbDstE,
        input logic [DATA_W-1:0] wbValE,
        input logic [3:0]        wbDstM,
        input logic [DATA_W-1:0] wbValM
    );
        if (id[3])             return '0;
        else if (wbDstM == id) return wbValM;
        else if (wbDstE == id) return wbValE;
        else                   return stored;
    endfunction

    assign rdA  = readReg(srcA, regFile[srcA[2:0]], wb_dstE, wb_valE, wb_dstM, wb_valM);
    assign rdB  = readReg(srcB, regFile[srcB[2:0]], wb_dstE, wb_valE, wb_dstM, wb_valM);
    assign valA = (d_icode == IJXX || d_icode == ICALL) ? d_valP : rdA;

`ifdef LOADUSE_DETECT_EN
    // A load still in E whose destination feeds this instruction cannot be forwarded.
    assign load_use_stall = E_valid && (E_icode == IMRMOVL || E_icode == IPOPL) &&
                            (E_dstM != RNONE) && d_valid &&
                            (E_dstM == srcA || E_dstM == srcB);
`else
    assign load_use_stall = 1'b0;
`endif

    assign bubble = e_bubble | load_use_stall | ~d_valid;

    // Writeback; the later M assignment overrides E on a same-register collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regFile[i] <= '0;
        end else begin
            if (!wb_dstE[3]) regFile[wb_dstE[2:0]] <= wb_valE;
            if (!wb_dstM[3]) regFile[wb_dstM[2:0]] <= wb_valM;
        end
    end

    // D->E pipeline register: bubble beats stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bubble) begin
            E_valid <= 1'b0;
            E_icode <= INOP;
            E_ifun  <= 4'h0;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
        end else if (!e_stall) begin
            E_valid <= 1'b1;
            E_icode <= d_icode;
            E_ifun  <= d_ifun;
            E_valC  <= d_valC;
            E_valA  <= valA;
            E_valB  <= rdB;
            E_srcA  <= srcA;
            E_srcB  <= srcB;
            E_dstE  <= dstE;
            E_dstM  <= dstM;
        end
    end

endmodule

// File: tb/tb_y86_decode_stage.sv
// tb_y86_decode_stage: directed-vector bench for y86_decode_stage with a
// rule-level reference model and a per-cycle compare process.
module tb_y86_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        d_valid = 1'b0;
    logic [3:0]  d_icode = 4'h1, d_ifun = 4'h0, d_rA = 4'hF, d_rB = 4'hF;
    logic [31:0] d_valC = '0, d_valP = '0;
    logic        e_stall = 1'b0, e_bubble = 1'b0;
    logic [3:0]  wb_dstE = 4'hF, wb_dstM = 4'hF;
    logic [31:0] wb_valE = '0, wb_valM = '0;

    logic        E_valid;
    logic [3:0]  E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM;
    logic [31:0] E_valC, E_valA, E_valB;
    logic        load_use_stall;

    int checks = 0;
    int failures = 0;
    bit cmpEn = 1'b0;

    always #5 clk = ~clk;

    y86_decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun), .d_rA(d_rA), .d_rB(d_rB),
        .d_valC(d_valC), .d_valP(d_valP),
        .e_stall(e_stall), .e_bubble(e_bubble),
        .wb_dstE(wb_dstE), .wb_valE(wb_valE), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
        .E_valid(E_valid), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .load_use_stall(load_use_stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (rule level) ----------------
    logic [31:0] mReg [8];
    logic        mValid;
    logic [3:0]  mIcode, mIfun, mSrcA, mSrcB, mDstE, mDstM;
    logic [31:0] mValC, mValA, mValB;

    function automatic logic [3:0] fSrcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction
    function automatic logic [3:0] fSrcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction
    function automatic logic [3:0] fDstE(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction
    function automatic logic [3:0] fDstM(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h5, 4'hB}) return ra;
        return 4'hF;
    endfunction
    function automatic logic [31:0] fRead(input logic [3:0] id);
        if (id >= 4'd8) return 32'h0;
        if (id == wb_dstM) return wb_valM;
        if (id == wb_dstE) return wb_valE;
        return mReg[id[2:0]];
    endfunction
    function automatic logic fLU();
`ifdef LOADUSE_DETECT_EN
        logic [3:0] sa, sb;
        sa = fSrcA(d_icode, d_rA);
        sb = fSrcB(d_icode, d_rB);
        return mValid && (mIcode == 4'h5 || mIcode == 4'hB) && mDstM != 4'hF && d_valid
               && (mDstM == sa || mDstM == sb);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mReg[i] <= 32'h0;
            mValid <= 1'b0; mIcode <= 4'h1; mIfun <= 4'h0;
            mValC <= 32'h0; mValA <= 32'h0; mValB <= 32'h0;
            mSrcA <= 4'hF; mSrcB <= 4'hF; mDstE <= 4'hF; mDstM <= 4'hF;
        end else begin
            if (wb_dstE < 4'd8) mReg[wb_dstE[2:0]] <= wb_valE;
            if (wb_dstM < 4'd8) mReg[wb_dstM[2:0]] <= wb_valM;
            if (e_bubble || fLU() || !d_valid) begin
                mValid <= 1'b0; mIcode <= 4'h1; mIfun <= 4'h0;
                mValC <= 32'h0; mValA <= 32'h0; mValB <= 32'h0;
                mSrcA <= 4'hF; mSrcB <= 4'hF; mDstE <= 4'hF; mDstM <= 4'hF;
            end else if (!e_stall) begin
                mValid <= 1'b1;
                mIcode <= d_icode;
                mIfun  <= d_ifun;
                mValC  <= d_valC;
                mValA  <= (d_icode inside {4'h7, 4'h8}) ? d_valP
                                                         : fRead(fSrcA(d_icode, d_rA));
                mValB  <= fRead(fSrcB(d_icode, d_rB));
                mSrcA  <= fSrcA(d_icode, d_rA);
                mSrcB  <= fSrcB(d_icode, d_rB);
                mDstE  <= fDstE(d_icode, d_rB);
                mDstM  <= fDstM(d_icode, d_rA);
            end
        end
    end

    // Compare process: every falling edge once enabled.
    always @(negedge clk) begin
        if (cmpEn) begin
            chk("cmp.E_valid", {31'b0, E_valid}, {31'b0, mValid});
            chk("cmp.E_icode", {28'b0, E_icode}, {28'b0, mIcode});
            chk("cmp.E_ifun",  {28'b0, E_ifun},  {28'b0, mIfun});
            chk("cmp.E_valC",  E_valC, mValC);
            chk("cmp.E_valA",  E_valA, mValA);
            chk("cmp.E_valB",  E_valB, mValB);
            chk("cmp.E_srcA",  {28'b0, E_srcA},  {28'b0, mSrcA});
            chk("cmp.E_srcB",  {28'b0, E_srcB},  {28'b0, mSrcB});
            chk("cmp.E_dstE",  {28'b0, E_dstE},  {28'b0, mDstE});
            chk("cmp.E_dstM",  {28'b0, E_dstM},  {28'b0, mDstM});
            chk("cmp.load_use_stall", {31'b0, load_use_stall}, {31'b0, fLU()});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [31:0] vc, input logic [31:0] vp);
        d_valid = v; d_icode = ic; d_ifun = 4'h0; d_rA = ra; d_rB = rb;
        d_valC = vc; d_valP = vp;
    endtask

    task automatic wb(input logic [3:0] de, input logic [31:0] ve,
                      input logic [3:0] dm, input logic [31:0] vm);
        wb_dstE = de; wb_valE = ve; wb_dstM = dm; wb_valM = vm;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) cyc();
        chk("reset.E_valid", {31'b0, E_valid}, 32'h0);
        chk("reset.E_icode", {28'b0, E_icode}, 32'h1);
        chk("reset.E_dstE",  {28'b0, E_dstE},  32'hF);
        chk("reset.E_valA",  E_valA, 32'h0);
        cmpEn = 1'b1;
        rst_n = 1'b1;

        // irmovl $0x1234, %edx
        drv(1'b1, 4'h3, 4'hF, 4'h2, 32'h1234, 32'h6);
        cyc();
        chk("irmovl.E_dstE",  {28'b0, E_dstE}, 32'h2);
        chk("irmovl.E_srcA",  {28'b0, E_srcA}, 32'hF);
        chk("irmovl.E_srcB",  {28'b0, E_srcB}, 32'hF);
        chk("irmovl.E_valC",  E_valC, 32'h1234);
        chk("irmovl.E_valid", {31'b0, E_valid}, 32'h1);

        // Preload R1=5, R3=7, then OPl %ecx,%ebx
        drv(1'b0, 4'h1, 4'hF, 4'hF, 32'h0, 32'h0);
        wb(4'h1, 32'h5, 4'hF, 32'h0); cyc();
        wb(4'h3, 32'h7, 4'hF, 32'h0); cyc();
        wb(4'hF, 32'h0, 4'hF, 32'h0);
        drv(1'b1, 4'h6, 4'h1, 4'h3, 32'h0, 32'h0);
        cyc();
        chk("opl.E_valA", E_valA, 32'h5);
        chk("opl.E_valB", E_valB, 32'h7);
        chk("opl.E_srcA", {28'b0, E_srcA}, 32'h1);
        chk("opl.E_srcB", {28'b0, E_srcB}, 32'h3);
        chk("opl.E_dstE", {28'b0, E_dstE}, 32'h3);

        // Write-through: R1 written in the same cycle it is read
        wb(4'h1, 32'h9, 4'hF, 32'h0);
        cyc();
        chk("bypass.E_valA", E_valA, 32'h9);

        // popl %esp-style collision on R4: valM wins
        drv(1'b1, 4'hB, 4'h4, 4'hF, 32'h0, 32'h0);
        wb(4'h4, 32'h100, 4'h4, 32'h200);
        cyc();
        chk("popl.E_valA", E_valA, 32'h200);
        chk("popl.E_valB", E_valB, 32'h200);
        chk("popl.E_dstM", {28'b0, E_dstM}, 32'h4);
        wb(4'hF, 32'h0, 4'hF, 32'h0);
        drv(1'b0, 4'h1, 4'hF, 4'hF, 32'h0, 32'h0);
        cyc();
        // rrmovl %esp,%eax reads back the stored R4
        drv(1'b1, 4'h2, 4'h4, 4'h0, 32'h0, 32'h0);
        cyc();
        chk("r4after.E_valA", E_valA, 32'h200);

        // call with valP=0x40, R4=0x80
        drv(1'b0, 4'h1, 4'hF, 4'hF, 32'h0, 32'h0);
        wb(4'h4, 32'h80, 4'hF, 32'h0); cyc();
        wb(4'hF, 32'h0, 4'hF, 32'h0);
        drv(1'b1, 4'h8, 4'hF, 4'hF, 32'h100, 32'h40);
        cyc();
        chk("call.E_valA", E_valA, 32'h40);
        chk("call.E_valB", E_valB, 32'h80);
        chk("call.E_dstE", {28'b0, E_dstE}, 32'h4);

        // jXX passes valP; undefined icode decodes to RNONE
        drv(1'b1, 4'h7, 4'hF, 4'hF, 32'h20, 32'h55);
        cyc();
        chk("jxx.E_valA", E_valA, 32'h55);
        drv(1'b1, 4'hC, 4'h1, 4'h3, 32'h0, 32'h0);
        cyc();
        chk("undef.E_srcA",  {28'b0, E_srcA}, 32'hF);
        chk("undef.E_dstE",  {28'b0, E_dstE}, 32'hF);
        chk("undef.E_valid", {31'b0, E_valid}, 32'h1);

        // Stall + bubble together -> NOP
        drv(1'b1, 4'h6, 4'h1, 4'h3, 32'h0, 32'h0);
        e_stall = 1'b1; e_bubble = 1'b1;
        cyc();
        chk("stbub.E_valid", {31'b0, E_valid}, 32'h0);
        chk("stbub.E_icode", {28'b0, E_icode}, 32'h1);
        e_stall = 1'b0; e_bubble = 1'b0;
        drv(1'b1, 4'h3, 4'hF, 4'h5, 32'hABCD, 32'h0);
        cyc();
        // Stall alone holds E for three cycles while D changes
        e_stall = 1'b1;
        drv(1'b1, 4'h3, 4'hF, 4'h6, 32'h5555, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall.E_valC", E_valC, 32'hABCD);
            chk("stall.E_dstE", {28'b0, E_dstE}, 32'h5);
        end
        e_stall = 1'b0;
        e_bubble = 1'b1;
        cyc();
        chk("bubble.E_valid", {31'b0, E_valid}, 32'h0);
        e_bubble = 1'b0;

        // Load-use: mrmovl into %esi, then rrmovl %esi,%ecx
        drv(1'b1, 4'h5, 4'h6, 4'hF, 32'h0, 32'h0);
        cyc();
        drv(1'b1, 4'h2, 4'h6, 4'h1, 32'h0, 32'h0);
        #1;
`ifdef LOADUSE_DETECT_EN
        chk("lu.load_use_stall", {31'b0, load_use_stall}, 32'h1);
        cyc();
        chk("lu.E_valid", {31'b0, E_valid}, 32'h0);
        cyc();
        chk("lu.E_icode", {28'b0, E_icode}, 32'h2);
`else
        chk("lu.load_use_stall", {31'b0, load_use_stall}, 32'h0);
        cyc();
        chk("lu.E_valid", {31'b0, E_valid}, 32'h1);
        chk("lu.E_icode", {28'b0, E_icode}, 32'h2);
`endif

        // Asynchronous reset mid-operation
        drv(1'b1, 4'h3, 4'hF, 4'h2, 32'h77, 32'h0);
        cyc();
        wb(4'h1, 32'h99, 4'hF, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst.E_valid", {31'b0, E_valid}, 32'h0);
        chk("midrst.E_icode", {28'b0, E_icode}, 32'h1);
        cyc();
        rst_n = 1'b1;
        wb(4'hF, 32'h0, 4'hF, 32'h0);
        drv(1'b1, 4'h6, 4'h1, 4'h3, 32'h0, 32'h0);
        cyc();
        chk("midrst.E_valA", E_valA, 32'h0);
        chk("midrst.E_valB", E_valB, 32'h0);

        drv(1'b0, 4'h1, 4'hF, 4'hF, 32'h0, 32'h0);
        repeat (2) cyc();
        cmpEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
